// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES round-subkey generator (PC-1, C/D rotation, PC-2) with valid/ready output
module des_key_schedule #(
    parameter int ROUNDS       = 16,
    parameter bit PARITY_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic        busy,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [47:0] subkey,
    output logic [3:0]  sk_round,
    output logic        sk_last,
    output logic        parity_err
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    function automatic int shamt(input logic [3:0] r);
        return (r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15) ? 1 : 2;
    endfunction

    function automatic int shift_sum();
        int s;
        s = 0;
        for (int i = 0; i < ROUNDS; i++) s += shamt(4'(i));
        return s % 28;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] v, input int n);
        logic [55:0] t;
        t = {v, v} << n;
        return t[55:28];
    endfunction

    localparam int         SHIFT_MOD = shift_sum();
    localparam logic [3:0] LAST      = 4'(ROUNDS - 1);

    state_t      state_q;
    logic [27:0] c_q, d_q, c_d, d_d, c_src, d_src;
    logic [3:0]  round_q;
    logic        mode_q, valid_q, perr_q;
    logic [55:0] pc1_v, cd;
    logic [7:0]  byte_odd;
    logic        par_ok, last, accept;
    int          n_rot;

    // Parity bits (key[8*b]) are never selected by PC-1, so they cannot reach the subkey.
    for (genvar j = 0; j < 56; j++) begin : g_pc1
        assign pc1_v[55-j] = key[64-PC1_T[j]];
    end

    assign cd = {c_q, d_q};
    for (genvar j = 0; j < 48; j++) begin : g_pc2
        assign subkey[47-j] = cd[56-PC2_T[j]];
    end

    for (genvar b = 0; b < 8; b++) begin : g_par
        assign byte_odd[b] = ^key[8*b +: 8];
    end

    assign par_ok = &byte_odd;
    assign last   = mode_q ? (round_q == 4'd0) : (round_q == LAST);
    assign accept = valid_q && sk_ready;

    // One rotator serves load (pre-rotation) and every advance; right shifts are left by 28-n.
    always_comb begin
        c_src = (state_q == IDLE) ? pc1_v[55:28] : c_q;
        d_src = (state_q == IDLE) ? pc1_v[27:0] : d_q;
        n_rot = (state_q == IDLE) ? (decrypt ? SHIFT_MOD : 1)
              : (mode_q ? 28 - shamt(round_q) : shamt(round_q + 4'd1));
        c_d   = rotl(c_src, n_rot);
        d_d   = rotl(d_src, n_rot);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            perr_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start && PARITY_CHECK && !par_ok) begin
                    perr_q <= 1'b1;
                end else if (start) begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                    mode_q  <= decrypt;
                    c_q     <= c_d;
                    d_q     <= d_d;
                    round_q <= decrypt ? LAST : 4'd0;
                end
            end else if (accept && last) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
            end else if (accept) begin
                c_q     <= c_d;
                d_q     <= d_d;
                round_q <= mode_q ? round_q - 4'd1 : round_q + 4'd1;
            end
        end
    end

    assign busy       = (state_q == RUN);
    assign sk_valid   = valid_q;
    assign sk_round   = round_q;
    assign sk_last    = valid_q && last;
    assign parity_err = perr_q;
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: randomized scoreboard bench for three builds of des_key_schedule against a textbook DES key-schedule model
module tb_des_key_schedule;
    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  rnd;
        logic        last;
    } exp_t;

    localparam logic [63:0] KAT = 64'h133457799BBCDFF1;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start [3];
    logic        decrypt [3];
    logic [63:0] key [3];
    logic        sk_ready [3];
    logic        busy [3];
    logic        sk_valid [3];
    logic [47:0] subkey [3];
    logic [3:0]  sk_round [3];
    logic        sk_last [3];
    logic        parity_err [3];

    exp_t q0[$], q1[$], q2[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_rdy = 1'b0;
    bit   stall_en = 1'b0;
    int   stall_cnt = 0;

    always #5 clk = ~clk;

    des_key_schedule #(.ROUNDS(16), .PARITY_CHECK(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start[0]), .decrypt(decrypt[0]), .key(key[0]),
        .busy(busy[0]), .sk_valid(sk_valid[0]), .sk_ready(sk_ready[0]), .subkey(subkey[0]),
        .sk_round(sk_round[0]), .sk_last(sk_last[0]), .parity_err(parity_err[0]));
    des_key_schedule #(.ROUNDS(16), .PARITY_CHECK(1'b0)) dut_np (
        .clk(clk), .reset(reset), .start(start[1]), .decrypt(decrypt[1]), .key(key[1]),
        .busy(busy[1]), .sk_valid(sk_valid[1]), .sk_ready(sk_ready[1]), .subkey(subkey[1]),
        .sk_round(sk_round[1]), .sk_last(sk_last[1]), .parity_err(parity_err[1]));
    des_key_schedule #(.ROUNDS(4), .PARITY_CHECK(1'b1)) dut_r4 (
        .clk(clk), .reset(reset), .start(start[2]), .decrypt(decrypt[2]), .key(key[2]),
        .busy(busy[2]), .sk_valid(sk_valid[2]), .sk_ready(sk_ready[2]), .subkey(subkey[2]),
        .sk_round(sk_round[2]), .sk_last(sk_last[2]), .parity_err(parity_err[2]));

    // Textbook key schedule: Kr = PC-2 of PC-1(key) halves each rotated left by the sum of shifts 1..r.
    function automatic logic [47:0] ref_key(input logic [63:0] k, input int r);
        bit c [28];
        bit d [28];
        int s;
        int p;
        logic [47:0] o;
        s = 0;
        for (int j = 0; j < r; j++) s += SH[j];
        for (int i = 0; i < 28; i++) begin
            c[i] = k[64 - PC1[(i + s) % 28]];
            d[i] = k[64 - PC1[28 + (i + s) % 28]];
        end
        for (int m = 0; m < 48; m++) begin
            p = PC2[m];
            o[47 - m] = (p <= 28) ? c[p - 1] : d[p - 29];
        end
        return o;
    endfunction

    function automatic logic [63:0] odd_key();
        logic [63:0] k;
        k = {$urandom, $urandom};
        for (int b = 0; b < 8; b++) if (^k[8*b +: 8] == 1'b0) k[8*b] = ~k[8*b];
        return k;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qfront(input int i);
        case (i)
            0: return q0[0];
            1: return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpop(input int i);
        case (i)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic qpush(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qclear(input int i);
        case (i)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    // Monitor: every valid cycle must match the queue head (so stalls must hold stable); pop on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (sk_valid[i] && qsize(i) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_subkey inst%0d: got %h round %0d", i, subkey[i], sk_round[i]);
                end else if (sk_valid[i]) begin
                    e = qfront(i);
                    chk($sformatf("inst%0d_sk_round_last", i),
                        64'({subkey[i], sk_round[i], sk_last[i]}), 64'(e));
                    if (sk_ready[i]) qpop(i);
                end
            end
        end
    end

    // Ready driver for the main instance: optional forced 10-cycle stall on round 2, else random or always-ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_en && sk_valid[0] && sk_round[0] == 4'd1 && stall_cnt < 10) begin
                sk_ready[0] = 1'b0;
                stall_cnt++;
            end else begin
                sk_ready[0] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    task automatic wait_done(input int i);
        int n;
        n = 0;
        while (qsize(i) != 0 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (qsize(i) != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout inst%0d: got %0d pending expected 0", i, qsize(i));
            qclear(i);
        end else begin
            @(posedge clk);
            #1;
            chk($sformatf("inst%0d_idle_after_last", i), 64'({busy[i], sk_valid[i]}), 64'(0));
        end
    endtask

    task automatic run(input int i, input logic dec, input logic [63:0] k, input bit wait_end);
        int r;
        int idx;
        exp_t e;
        r = (i == 2) ? 4 : 16;
        for (int n = 0; n < r; n++) begin
            idx = dec ? r - n : n + 1;
            e.sk = ref_key(k, idx);
            e.rnd = 4'(idx - 1);
            e.last = (n == r - 1);
            qpush(i, e);
        end
        @(posedge clk);
        #1;
        start[i] = 1'b1;
        decrypt[i] = dec;
        key[i] = k;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        key[i] = {$urandom, $urandom};
        decrypt[i] = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk($sformatf("inst%0d_first_valid_busy_perr", i),
            64'({sk_valid[i], busy[i], parity_err[i]}), 64'(3'b110));
        if (wait_end) wait_done(i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] k;
        int n;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            decrypt[i] = 1'b0;
            key[i] = '0;
            sk_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("inst%0d_reset_state", i),
                64'({busy[i], sk_valid[i], sk_last[i], parity_err[i], sk_round[i], subkey[i]}), 64'(0));
        reset = 1'b0;

        chk("kat_k1", 64'(ref_key(KAT, 1)), 64'h1B02EFFC7072);
        chk("kat_k2", 64'(ref_key(KAT, 2)), 64'h79AED9DBC9E5);
        chk("kat_k16", 64'(ref_key(KAT, 16)), 64'hCB3D8B0E17F5);

        run(0, 1'b0, KAT, 1'b1);
        run(0, 1'b1, KAT, 1'b1);

        stall_cnt = 0;
        stall_en = 1'b1;
        rand_rdy = 1'b1;
        run(0, 1'b0, KAT, 1'b1);
        chk("stall_cycles", 64'(stall_cnt), 64'(10));
        stall_en = 1'b0;
        for (int t = 0; t < 6; t++) run(0, 1'($urandom_range(0, 1)), odd_key(), 1'b1);
        rand_rdy = 1'b0;

        @(posedge clk);
        #1;
        start[0] = 1'b1;
        key[0] = 64'h0;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        @(negedge clk);
        chk("perr_pulse", 64'({parity_err[0], busy[0], sk_valid[0]}), 64'(3'b100));
        @(negedge clk);
        chk("perr_one_cycle", 64'({parity_err[0], busy[0], sk_valid[0]}), 64'(0));
        run(1, 1'b0, 64'h0, 1'b1);
        k = odd_key();
        k[8] = ~k[8];
        run(1, 1'b1, k, 1'b1);
        run(1, 1'b0, k, 1'b1);

        run(0, 1'b0, KAT, 1'b0);
        n = 0;
        while (q0.size() > 11 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q0.delete();
        chk("reset_mid_run", 64'({busy[0], sk_valid[0], sk_last[0], sk_round[0], subkey[0]}), 64'(0));
        @(negedge clk);
        chk("reset_stays_idle", 64'({busy[0], sk_valid[0]}), 64'(0));

        run(0, 1'b0, KAT, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        start[0] = 1'b1;
        decrypt[0] = 1'b1;
        key[0] = odd_key();
        repeat (2) @(posedge clk);
        #1;
        start[0] = 1'b0;
        wait_done(0);
        repeat (5) @(negedge clk);
        chk("start_while_busy_ignored", 64'({busy[0], sk_valid[0]}), 64'(0));

        run(2, 1'b0, KAT, 1'b1);
        run(2, 1'b1, KAT, 1'b1);
        for (int t = 0; t < 3; t++) run(2, 1'($urandom_range(0, 1)), odd_key(), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
